// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, BOOT/RUN/HALT control and a 2-entry
// {instr, pc} buffer feeding the decode stage, with redirect and halt handling.
module fetch_unit #(
  parameter logic [9:0]  RESET_PC   = 10'h000,
  parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [9:0]  redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [9:0]  out_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [9:0]  pc;
  } entry_t;

  state_t     state, state_nxt;
  logic [9:0] pc, pc_nxt;
  logic [1:0] count, count_nxt;
  entry_t     head, head_nxt;
  entry_t     tail, tail_nxt;
  entry_t     fetched;
  logic       pop, fetch, redirect_take, fetch_is_halt;

  // Handshake: an entry transfers to decode on every cycle where out_valid and
  // out_ready are both high; out_* hold steady while out_valid && !out_ready.
  assign pop           = out_valid & out_ready;
  assign fetch         = (state == RUN) & ((count < 2'd2) | pop);
  assign redirect_take = redirect_valid & (state != BOOT);
  assign fetch_is_halt = fetch & (imem_instr == HALT_INSTR);
  assign fetched       = '{instr: imem_instr, pc: pc};

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = out_valid ? head.instr : 32'h0;
  assign out_pc    = out_valid ? head.pc : 10'h0;
  assign halted    = (state == HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT;
      pc    <= RESET_PC;
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      count <= count_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = count;
    head_nxt  = head;
    tail_nxt  = tail;

    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (fetch_is_halt) state_nxt = HALT;
      HALT:    state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase

    // Redirect wins over everything else in the cycle, including halt detection.
    if (redirect_take) begin
      state_nxt = RUN;
      pc_nxt    = redirect_addr;
      count_nxt = 2'd0;
    end else begin
      if (fetch) pc_nxt = pc + 10'd1;
      case ({fetch, pop})
        2'b11: begin
          if (count == 2'd2) begin
            head_nxt = tail;
            tail_nxt = fetched;
          end else begin
            head_nxt = fetched;
          end
        end
        2'b10: begin
          if (count == 2'd0) head_nxt = fetched;
          else               tail_nxt = fetched;
          count_nxt = count + 2'd1;
        end
        2'b01: begin
          head_nxt  = tail;
          count_nxt = count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked against a queue-based behavioural model of the fetch buffer.
module tb_fetch_unit;

  localparam logic [9:0]  RESET_PC = 10'h000;
  localparam logic [31:0] HALT     = 32'h00000073;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [9:0]  redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic        halted;

  logic [31:0] mem [0:1023];

  logic [9:0]  m_pc;
  int          m_phase;          // 0 boot, 1 run, 2 halt
  bit          m_known;
  logic [41:0] exp_q[$];         // {pc, instr} in delivery order

  int n_checks;
  int n_pass;
  int n_fail;

  fetch_unit #(.RESET_PC(RESET_PC), .HALT_INSTR(HALT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  assign imem_instr = mem[imem_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [41:0] obs, input logic [41:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [41:0] hd;
    hd = (exp_q.size() != 0) ? exp_q[0] : 42'h0;
    check("out_valid", out_valid, exp_q.size() != 0);
    check("out_pc", out_pc, hd[41:32]);
    check("out_instr", out_instr, hd[31:0]);
    check("imem_addr", imem_addr, m_pc);
    check("halted", halted, m_phase == 2);
  endtask

  // One clock cycle: check outputs, apply inputs, advance the model, clock.
  task automatic step(input bit rst, input bit rdy, input bit redir, input logic [9:0] raddr);
    int  n;
    bit  pop, fetch;
    if (m_known) check_model();
    rst_n          = !rst;
    out_ready      = rdy;
    redirect_valid = redir;
    redirect_addr  = raddr;
    if (rst) begin
      m_pc    = RESET_PC;
      m_phase = 0;
      m_known = 1;
      exp_q.delete();
    end else if (m_known) begin
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (redir) begin
        exp_q.delete();
        m_pc    = raddr;
        m_phase = 1;
      end else begin
        n     = exp_q.size();
        pop   = (n != 0) && rdy;
        fetch = (m_phase == 1) && ((n < 2) || pop);
        if (pop) void'(exp_q.pop_front());
        if (fetch) begin
          exp_q.push_back({m_pc, mem[m_pc]});
          if (mem[m_pc] == HALT) m_phase = 2;
          m_pc = m_pc + 10'd1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    m_known  = 0;
    m_phase  = 0;
    m_pc     = RESET_PC;
    rst_n    = 1'b0;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 10'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;

    // Reset, with a redirect asserted that must be ignored.
    step(1, 1, 1, 10'h155);
    step(1, 1, 0, 10'h0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_halted", halted, 1'b0);

    // Startup latency: BOOT, fetch addr 0, first instruction out.
    step(0, 1, 1, 10'h2AA);
    check("boot_addr", imem_addr, 10'h000);
    check("boot_valid", out_valid, 1'b0);
    step(0, 1, 0, 10'h0);
    check("first_valid", out_valid, 1'b1);
    check("first_pc", out_pc, 10'h000);
    check("first_instr", out_instr, 32'h1000_0000);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 10'h0);

    // Backpressure: buffer fills, PC freezes, head held.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 10'h0);
    check("stall_pc", out_pc, 10'h004);
    check("stall_instr", out_instr, 32'h1000_0004);
    check("stall_addr", imem_addr, 10'h006);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 10'h0);

    // Redirect with a full buffer.
    step(0, 0, 0, 10'h0);
    step(0, 0, 0, 10'h0);
    step(0, 1, 1, 10'h080);
    check("redir_valid", out_valid, 1'b0);
    check("redir_addr", imem_addr, 10'h080);
    step(0, 1, 0, 10'h0);
    check("redir_pc", out_pc, 10'h080);
    check("redir_out_valid", out_valid, 1'b1);

    // PC wrap at the top of the address space.
    step(0, 1, 1, 10'h3FE);
    step(0, 1, 0, 10'h0);
    check("wrap_0", out_pc, 10'h3FE);
    step(0, 1, 0, 10'h0);
    check("wrap_1", out_pc, 10'h3FF);
    step(0, 1, 0, 10'h0);
    check("wrap_2", out_pc, 10'h000);
    step(0, 1, 0, 10'h0);
    check("wrap_3", out_pc, 10'h001);

    // Halt on ECALL at word 5, then resume via redirect.
    mem[5] = HALT;
    step(0, 1, 1, 10'h000);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 10'h0);
    check("halt_flag", halted, 1'b1);
    check("halt_addr", imem_addr, 10'h006);
    check("halt_drained", out_valid, 1'b0);
    step(0, 1, 1, 10'h010);
    check("resume_halted", halted, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 10'h0);

    // Reset while halted with a full buffer.
    step(0, 0, 1, 10'h004);
    step(0, 0, 0, 10'h0);
    step(0, 0, 0, 10'h0);
    check("pre_rst_halted", halted, 1'b1);
    check("pre_rst_valid", out_valid, 1'b1);
    step(1, 0, 1, 10'h123);
    check("post_rst_valid", out_valid, 1'b0);
    check("post_rst_halted", halted, 1'b0);
    check("post_rst_addr", imem_addr, RESET_PC);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 10'h0);

    // Random traffic with sprinkled halts, redirects and resets.
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom();
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0, 10'($urandom_range(0, 1023)));
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
